// File: rtl/collision_detector_all.sv
// Per-pixel collision detector: reports the first overlap of each object pair per frame
// as a one-cycle pulse and publishes a per-frame collision summary at start of frame.
module collision_detector_all #(
   parameter int ENEMY_BIKES_COUNT        = 8,
   parameter int PLAYER_PROJECTILES_COUNT = 4
) (
   input  logic                                clk,
   input  logic                                resetN,
   input  logic                                startOfFrame,
   input  logic                                playerDrawingRequest,
   input  logic [ENEMY_BIKES_COUNT-1:0]        bikersDrawingRequest,
   input  logic                                treeDrawingRequest,
   input  logic                                truckDrawingRequest,
   input  logic                                powerupDrawingRequest,
   input  logic                                HUDdrawingRequest,
   input  logic [ENEMY_BIKES_COUNT-1:0]        enemyProjectilesRequest,
   input  logic [PLAYER_PROJECTILES_COUNT-1:0] playerProjectilesRequest,
   output logic                                playerBikerHit,
   output logic                                playerShot,
   output logic                                playerTreeHit,
   output logic                                playerTruckHit,
   output logic                                powerupTaken,
   output logic [ENEMY_BIKES_COUNT-1:0]        bikerHit,
   output logic [PLAYER_PROJECTILES_COUNT-1:0] projectileConsumed,
   output logic [7:0]                          frameCollisionCount,
   output logic                                frameAnyCollision
);

   localparam int NT = 5 + ENEMY_BIKES_COUNT + PLAYER_PROJECTILES_COUNT;
   localparam int CW = $clog2(NT + 1);
   localparam int BH = 5;
   localparam int PC = 5 + ENEMY_BIKES_COUNT;

   function automatic logic [CW-1:0] popcount(input logic [NT-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int k = 0; k < NT; k++) begin
         c = c + {{(CW-1){1'b0}}, v[k]};
      end
      return c;
   endfunction

   logic [NT-1:0] terms_s;
   logic [NT-1:0] fire_s;
   logic [NT-1:0] flags_next_s;
   logic [8:0]    sum_s;
   logic [7:0]    cnt_next_s;

   logic [NT-1:0] flags_r;
   logic [NT-1:0] pulses_r;
   logic [7:0]    cnt_r;
   logic [7:0]    frame_count_r;
   logic          frame_any_r;

   // Overlap terms for this pixel, all masked on HUD pixels
   always_comb begin
      logic valid_s;
      logic any_biker_s;
      logic any_pproj_s;
      terms_s     = '0;
      valid_s     = ~HUDdrawingRequest;
      any_biker_s = |bikersDrawingRequest;
      any_pproj_s = |playerProjectilesRequest;
      terms_s[0]  = valid_s & playerDrawingRequest & any_biker_s;
      terms_s[1]  = valid_s & playerDrawingRequest & (|enemyProjectilesRequest);
      terms_s[2]  = valid_s & playerDrawingRequest & treeDrawingRequest;
      terms_s[3]  = valid_s & playerDrawingRequest & truckDrawingRequest;
      terms_s[4]  = valid_s & playerDrawingRequest & powerupDrawingRequest;
      for (int j = 0; j < ENEMY_BIKES_COUNT; j++) begin
         terms_s[BH+j] = valid_s & bikersDrawingRequest[j] & any_pproj_s;
      end
      for (int i = 0; i < PLAYER_PROJECTILES_COUNT; i++) begin
         terms_s[PC+i] = valid_s & playerProjectilesRequest[i] & any_biker_s;
      end
   end

   // Start of frame re-arms every flag before this pixel is judged
   always_comb begin
      fire_s       = '0;
      flags_next_s = flags_r;
      sum_s        = 9'd0;
      cnt_next_s   = cnt_r;
      if (startOfFrame) begin
         fire_s       = terms_s;
         flags_next_s = terms_s;
         sum_s        = {{(9-CW){1'b0}}, popcount(fire_s)};
      end else begin
         fire_s       = terms_s & ~flags_r;
         flags_next_s = flags_r | fire_s;
         sum_s        = {1'b0, cnt_r} + {{(9-CW){1'b0}}, popcount(fire_s)};
      end
      if (sum_s > 9'd255) begin
         cnt_next_s = 8'hFF;
      end else begin
         cnt_next_s = sum_s[7:0];
      end
   end

   // Pulse, flag, counter and summary registers
   always_ff @(posedge clk) begin
      if (!resetN) begin
         flags_r       <= '0;
         pulses_r      <= '0;
         cnt_r         <= 8'd0;
         frame_count_r <= 8'd0;
         frame_any_r   <= 1'b0;
      end else begin
         flags_r  <= flags_next_s;
         pulses_r <= fire_s;
         cnt_r    <= cnt_next_s;
         if (startOfFrame) begin
            frame_count_r <= cnt_r;
            frame_any_r   <= (cnt_r != 8'd0);
         end
      end
   end

   assign playerBikerHit      = pulses_r[0];
   assign playerShot          = pulses_r[1];
   assign playerTreeHit       = pulses_r[2];
   assign playerTruckHit      = pulses_r[3];
   assign powerupTaken        = pulses_r[4];
   assign bikerHit            = pulses_r[BH +: ENEMY_BIKES_COUNT];
   assign projectileConsumed  = pulses_r[PC +: PLAYER_PROJECTILES_COUNT];
   assign frameCollisionCount = frame_count_r;
   assign frameAnyCollision   = frame_any_r;

endmodule

// File: tb/tb_collision_detector_all.sv
// Self-checking bench for collision_detector_all: directed scenarios plus randomized
// traffic compared against a frame-level reference model.
module tb_collision_detector_all;

   localparam int E  = 8;
   localparam int P  = 4;
   localparam int NT = 5 + E + P;

   logic         clk = 1'b0;
   logic         resetN = 1'b0;
   logic         startOfFrame = 1'b0;
   logic         playerDrawingRequest = 1'b0;
   logic [E-1:0] bikersDrawingRequest = '0;
   logic         treeDrawingRequest = 1'b0;
   logic         truckDrawingRequest = 1'b0;
   logic         powerupDrawingRequest = 1'b0;
   logic         HUDdrawingRequest = 1'b0;
   logic [E-1:0] enemyProjectilesRequest = '0;
   logic [P-1:0] playerProjectilesRequest = '0;
   logic         playerBikerHit, playerShot, playerTreeHit, playerTruckHit, powerupTaken;
   logic [E-1:0] bikerHit;
   logic [P-1:0] projectileConsumed;
   logic [7:0]   frameCollisionCount;
   logic         frameAnyCollision;

   wire [NT-1:0] dut_pulses = {projectileConsumed, bikerHit, powerupTaken, playerTruckHit,
                               playerTreeHit, playerShot, playerBikerHit};

   int passed = 0;
   int total  = 0;

   // reference model state
   bit          rep [NT];
   int          m_cnt = 0;
   int          m_fc  = 0;
   bit          m_any = 1'b0;
   bit [NT-1:0] m_pulse = '0;

   collision_detector_all #(.ENEMY_BIKES_COUNT(E), .PLAYER_PROJECTILES_COUNT(P)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .playerDrawingRequest(playerDrawingRequest), .bikersDrawingRequest(bikersDrawingRequest),
      .treeDrawingRequest(treeDrawingRequest), .truckDrawingRequest(truckDrawingRequest),
      .powerupDrawingRequest(powerupDrawingRequest), .HUDdrawingRequest(HUDdrawingRequest),
      .enemyProjectilesRequest(enemyProjectilesRequest),
      .playerProjectilesRequest(playerProjectilesRequest),
      .playerBikerHit(playerBikerHit), .playerShot(playerShot), .playerTreeHit(playerTreeHit),
      .playerTruckHit(playerTruckHit), .powerupTaken(powerupTaken), .bikerHit(bikerHit),
      .projectileConsumed(projectileConsumed), .frameCollisionCount(frameCollisionCount),
      .frameAnyCollision(frameAnyCollision));

   always #5 clk = ~clk;

   // Which object pairs overlap on this pixel, straight from the collision rules
   function automatic bit [NT-1:0] spec_terms();
      bit [NT-1:0] t;
      int nb, ne, np;
      t  = '0;
      nb = $countones(bikersDrawingRequest);
      ne = $countones(enemyProjectilesRequest);
      np = $countones(playerProjectilesRequest);
      if (HUDdrawingRequest) return t;
      if (playerDrawingRequest) begin
         t[0] = (nb > 0);
         t[1] = (ne > 0);
         t[2] = treeDrawingRequest;
         t[3] = truckDrawingRequest;
         t[4] = powerupDrawingRequest;
      end
      for (int j = 0; j < E; j++) t[5+j] = bikersDrawingRequest[j] && (np > 0);
      for (int i = 0; i < P; i++) t[5+E+i] = playerProjectilesRequest[i] && (nb > 0);
      return t;
   endfunction

   task automatic model_edge();
      bit [NT-1:0] t;
      int n;
      if (!resetN) begin
         foreach (rep[k]) rep[k] = 1'b0;
         m_cnt = 0; m_fc = 0; m_any = 1'b0; m_pulse = '0;
         return;
      end
      t = spec_terms();
      if (startOfFrame) begin
         m_fc  = m_cnt;
         m_any = (m_cnt != 0);
         m_cnt = 0;
         foreach (rep[k]) rep[k] = 1'b0;
      end
      n = 0;
      for (int k = 0; k < NT; k++) begin
         m_pulse[k] = t[k] && !rep[k];
         if (m_pulse[k]) begin
            rep[k] = 1'b1;
            n++;
         end
      end
      m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      startOfFrame = 1'b0; playerDrawingRequest = 1'b0; bikersDrawingRequest = '0;
      treeDrawingRequest = 1'b0; truckDrawingRequest = 1'b0; powerupDrawingRequest = 1'b0;
      HUDdrawingRequest = 1'b0; enemyProjectilesRequest = '0; playerProjectilesRequest = '0;
   endtask

   task automatic sof();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      idle();
      tick(); tick();
      total++;
      if (dut_pulses !== '0 || frameCollisionCount !== 8'd0 || frameAnyCollision !== 1'b0) begin
         $display("FAIL reset: pulses=%h count=%0d any=%b, required 0/0/0",
                  dut_pulses, frameCollisionCount, frameAnyCollision);
      end else passed++;
      resetN = 1'b1;
      tick();
   endtask

   task automatic test_player_biker();
      int npulse;
      sof();
      playerDrawingRequest = 1'b1; bikersDrawingRequest = 8'h08;
      npulse = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (c == 0) begin
            total++;
            if (playerBikerHit !== 1'b1) $display("FAIL biker_first: playerBikerHit=%b, required 1", playerBikerHit);
            else passed++;
         end
         if (playerBikerHit === 1'b1) npulse++;
      end
      idle();
      tick();
      total++;
      if (npulse != 1) $display("FAIL biker_once: pulses=%0d, required 1", npulse);
      else passed++;
      sof();
      total++;
      if (frameCollisionCount !== 8'd1 || frameAnyCollision !== 1'b1)
         $display("FAIL biker_summary: count=%0d any=%b, required 1/1", frameCollisionCount, frameAnyCollision);
      else passed++;
   endtask

   task automatic test_projectiles();
      bikersDrawingRequest = 8'h81; playerProjectilesRequest = 4'b0010;
      tick();
      total++;
      if (bikerHit !== 8'h81 || projectileConsumed !== 4'b0010 || playerBikerHit !== 1'b0)
         $display("FAIL proj_hit: bikerHit=%h consumed=%b pb=%b, required 81/0010/0",
                  bikerHit, projectileConsumed, playerBikerHit);
      else passed++;
      idle();
      tick();
      sof();
      total++;
      if (frameCollisionCount !== 8'd3) $display("FAIL proj_summary: count=%0d, required 3", frameCollisionCount);
      else passed++;
   endtask

   task automatic test_hud();
      bikersDrawingRequest = 8'h81; playerProjectilesRequest = 4'b0010;
      playerDrawingRequest = 1'b1; treeDrawingRequest = 1'b1; HUDdrawingRequest = 1'b1;
      tick();
      total++;
      if (dut_pulses !== '0) $display("FAIL hud_mask: pulses=%h, required 0", dut_pulses);
      else passed++;
      idle();
      sof();
      total++;
      if (frameCollisionCount !== 8'd0 || frameAnyCollision !== 1'b0)
         $display("FAIL hud_summary: count=%0d any=%b, required 0/0", frameCollisionCount, frameAnyCollision);
      else passed++;
   endtask

   task automatic test_sof_overlap();
      playerDrawingRequest = 1'b1; treeDrawingRequest = 1'b1;
      tick();
      idle();
      playerDrawingRequest = 1'b1; truckDrawingRequest = 1'b1;
      tick();
      idle();
      tick();
      playerDrawingRequest = 1'b1; powerupDrawingRequest = 1'b1; startOfFrame = 1'b1;
      tick();
      total++;
      if (frameCollisionCount !== 8'd2 || powerupTaken !== 1'b1)
         $display("FAIL sof_overlap: count=%0d powerupTaken=%b, required 2/1", frameCollisionCount, powerupTaken);
      else passed++;
      idle();
      tick();
      sof();
      total++;
      if (frameCollisionCount !== 8'd1) $display("FAIL sof_follow: count=%0d, required 1", frameCollisionCount);
      else passed++;
   endtask

   task automatic test_all_terms();
      playerDrawingRequest = 1'b1; bikersDrawingRequest = 8'hFF; enemyProjectilesRequest = 8'hFF;
      treeDrawingRequest = 1'b1; truckDrawingRequest = 1'b1; powerupDrawingRequest = 1'b1;
      playerProjectilesRequest = 4'hF;
      tick();
      total++;
      if (dut_pulses !== 17'h1FFFF) $display("FAIL all_terms: pulses=%h, required 1ffff", dut_pulses);
      else passed++;
      tick();
      total++;
      if (dut_pulses !== '0) $display("FAIL all_repeat: pulses=%h, required 0", dut_pulses);
      else passed++;
      idle();
      sof();
      total++;
      if (frameCollisionCount !== 8'd17 || frameAnyCollision !== 1'b1)
         $display("FAIL all_summary: count=%0d any=%b, required 17/1", frameCollisionCount, frameAnyCollision);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      playerDrawingRequest = 1'b1; treeDrawingRequest = 1'b1; tick(); idle();
      playerDrawingRequest = 1'b1; truckDrawingRequest = 1'b1; tick(); idle();
      playerDrawingRequest = 1'b1; powerupDrawingRequest = 1'b1; tick(); idle();
      playerDrawingRequest = 1'b1; bikersDrawingRequest = 8'h01; resetN = 1'b0;
      tick();
      total++;
      if (dut_pulses !== '0 || frameCollisionCount !== 8'd0 || frameAnyCollision !== 1'b0)
         $display("FAIL midreset: pulses=%h count=%0d any=%b, required 0/0/0",
                  dut_pulses, frameCollisionCount, frameAnyCollision);
      else passed++;
      resetN = 1'b1;
      tick();
      total++;
      if (playerBikerHit !== 1'b1) $display("FAIL post_reset_hit: playerBikerHit=%b, required 1", playerBikerHit);
      else passed++;
      idle();
      sof();
      total++;
      if (frameCollisionCount !== 8'd1) $display("FAIL post_reset_summary: count=%0d, required 1", frameCollisionCount);
      else passed++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int c = 0; c < 2000; c++) begin
         resetN                   = ($urandom_range(0, 299) != 0);
         startOfFrame             = ($urandom_range(0, 39) == 0);
         HUDdrawingRequest        = ($urandom_range(0, 3) == 0);
         playerDrawingRequest     = $urandom_range(0, 1);
         bikersDrawingRequest     = E'($urandom & $urandom & $urandom);
         enemyProjectilesRequest  = E'($urandom & $urandom & $urandom & $urandom);
         playerProjectilesRequest = P'($urandom & $urandom);
         treeDrawingRequest       = ($urandom_range(0, 7) == 0);
         truckDrawingRequest      = ($urandom_range(0, 7) == 0);
         powerupDrawingRequest    = ($urandom_range(0, 7) == 0);
         tick();
         total++;
         if (dut_pulses !== m_pulse || frameCollisionCount !== 8'(m_fc) || frameAnyCollision !== m_any) begin
            if (errs < 10)
               $display("FAIL random c%0d: pulses=%h count=%0d any=%b, required %h/%0d/%b",
                        c, dut_pulses, frameCollisionCount, frameAnyCollision, m_pulse, m_fc, m_any);
            errs++;
         end else passed++;
      end
      resetN = 1'b1;
      idle();
   endtask

   initial begin
      test_reset();
      test_player_biker();
      test_projectiles();
      test_hud();
      test_sof_overlap();
      test_all_terms();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
